// File: rtl/spi_master_if.sv
// Host-side and serial-side signal bundle for spi_master.
// The master modport is the controller's view; slave is the client/peripheral view.
interface spi_master_if #(
  parameter int unsigned MAX_WIDTH = 8,
  parameter int unsigned LEN_W     = 8
);
  logic                 start;
  logic [MAX_WIDTH-1:0] tx_data;
  logic [LEN_W-1:0]     len;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [MAX_WIDTH-1:0] rx_data;
  logic                 spi_clk;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic                 spi_cs;

  modport master (
    input  start, tx_data, len, spi_miso,
    output busy, done, err, rx_data, spi_clk, spi_mosi, spi_cs
  );

  modport slave (
    output start, tx_data, len, spi_miso,
    input  busy, done, err, rx_data, spi_clk, spi_mosi, spi_cs
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI master with variable transfer length (1..MAX_WIDTH bits, MSB first).
// Each non-idle state lasts HALF_DIV clk cycles; all outputs are registered.
module spi_master #(
  parameter int unsigned MAX_WIDTH = 8,
  parameter int unsigned HALF_DIV  = 2,
  parameter int unsigned LEN_W     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_master_if.master  bus
);

  localparam int unsigned PhW = 8;

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold, StGap} state_e;

  state_e               state_q, state_d;
  logic [PhW-1:0]       phase_q, phase_d;
  logic [LEN_W-1:0]     bit_q, bit_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [MAX_WIDTH-1:0] tx_q, tx_d;
  logic [MAX_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [MAX_WIDTH-1:0] rx_q, rx_d;
  logic                 clk_q, clk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_q, cs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 phase_last;
  logic                 len_ok;
  logic [MAX_WIDTH-1:0] tx_aligned;

  assign phase_last = (phase_q == PhW'(HALF_DIV - 1));
  assign len_ok     = (bus.len != '0) && (bus.len <= LEN_W'(MAX_WIDTH));
  // Left-justify the word so the next bit to send is always the MSB of tx_q.
  assign tx_aligned = bus.tx_data << (LEN_W'(MAX_WIDTH) - bus.len);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    len_d   = len_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    clk_d   = clk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q != StIdle) begin
      phase_d = phase_last ? '0 : phase_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (len_ok) begin
            len_d   = bus.len;
            tx_d    = tx_aligned;
            mosi_d  = tx_aligned[MAX_WIDTH-1];
            cs_d    = 1'b0;
            busy_d  = 1'b1;
            bit_d   = '0;
            rx_sh_d = '0;
            phase_d = '0;
            state_d = StSetup;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSetup: begin
        if (phase_last) begin
          clk_d   = 1'b1;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (phase_last) begin
          rx_sh_d = {rx_sh_q[MAX_WIDTH-2:0], bus.spi_miso};
          clk_d   = 1'b0;
          bit_d   = bit_q + 1'b1;
          state_d = StLow;
          if ((bit_q + 1'b1) < len_q) begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[MAX_WIDTH-2];
          end
        end
      end
      StLow: begin
        if (phase_last) begin
          if (bit_q == len_q) begin
            state_d = StHold;
          end else begin
            clk_d   = 1'b1;
            state_d = StHigh;
          end
        end
      end
      StHold: begin
        if (phase_last) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          rx_d    = rx_sh_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (phase_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= '0;
      len_q   <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      clk_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      clk_q   <= clk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rx_data  = rx_q;
  assign bus.spi_clk  = clk_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.spi_cs   = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master with a behavioural SPI slave and transfer model.
// Extra instances at HALF_DIV=1 and 4 check chip-select timing and gap length.
module tb_spi_master;

  localparam int unsigned Hd = 2;

  logic clk;
  logic rst_n;

  spi_master_if #(.MAX_WIDTH(8), .LEN_W(8)) bus ();
  spi_master_if #(.MAX_WIDTH(8), .LEN_W(8)) bus1 ();
  spi_master_if #(.MAX_WIDTH(8), .LEN_W(8)) bus4 ();

  spi_master #(.MAX_WIDTH(8), .HALF_DIV(Hd), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  spi_master #(.MAX_WIDTH(8), .HALF_DIV(1), .LEN_W(8)) dut_hd1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  spi_master #(.MAX_WIDTH(8), .HALF_DIV(4), .LEN_W(8)) dut_hd4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural slave: captures MOSI on rising spi_clk, presents its word MSB first.
  logic [7:0] slv_word = 8'h00;
  logic [7:0] slv_rx   = 8'h00;
  int         rises    = 0;
  logic       miso_bit;

  always @(negedge bus.spi_cs or posedge bus.spi_clk) begin
    if (bus.spi_clk) begin
      rises  <= rises + 1;
      slv_rx <= {slv_rx[6:0], bus.spi_mosi};
    end else begin
      rises  <= 0;
      slv_rx <= 8'h00;
    end
  end

  // Bits already shifted out = falling edges seen = rises minus an edge still high.
  always_comb begin
    int idx;
    idx = 7 - (rises - int'(bus.spi_clk));
    miso_bit = (idx >= 0 && idx < 8) ? slv_word[idx] : 1'b0;
  end

  assign bus.spi_miso  = miso_bit;
  assign bus1.spi_miso = 1'b0;
  assign bus4.spi_miso = 1'b0;

  logic [1:0] xcs, xclk, xdone;
  assign xcs   = {bus4.spi_cs, bus1.spi_cs};
  assign xclk  = {bus4.spi_clk, bus1.spi_clk};
  assign xdone = {bus4.done, bus1.done};

  logic [7:0] last_rx = 8'h00;

  // Starts a transfer at the current negedge and follows it to the done pulse.
  task automatic run_xfer(input logic [7:0] tx, input int l, input logic [7:0] sw,
                          input bit keep, input bit poke);
    int k, lowc, hic, busyc, errc, total;
    logic [7:0] t, exp_slv, exp_rx;
    t       = tx;
    exp_slv = 8'((32'(tx)) & ((32'd1 << l) - 1));
    exp_rx  = 8'(32'(sw) >> (8 - l));
    total   = (2 * l + 2) * Hd + 1;
    slv_word    = sw;
    bus.tx_data = tx;
    bus.len     = 8'(l);
    bus.start   = 1'b1;
    k = 0; lowc = 0; hic = 0; busyc = 0; errc = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check_eq("accept_busy", 32'(bus.busy), 32'd1);
        check_eq("accept_cs", 32'(bus.spi_cs), 32'd0);
        check_eq("first_mosi", 32'(bus.spi_mosi), 32'(t[l-1]));
        if (!keep) bus.start = 1'b0;
      end
      if (poke && k == 3) begin
        bus.start = 1'b1;
        bus.len   = 8'($urandom_range(0, 15));
      end
      if (poke && k == 4) bus.start = 1'b0;
      if (!bus.spi_cs) lowc++;
      if (bus.spi_clk) hic++;
      if (bus.busy) busyc++;
      if (bus.err) errc++;
    end while (!bus.done && k < total + 20);
    check_eq("done_latency", 32'(k), 32'(total));
    check_eq("rx_data", 32'(bus.rx_data), 32'(exp_rx));
    check_eq("slave_rx", 32'(slv_rx), 32'(exp_slv));
    check_eq("clk_rises", 32'(rises), 32'(l));
    check_eq("cs_low_cycles", 32'(lowc), 32'((2 * l + 2) * Hd));
    check_eq("clk_high_cycles", 32'(hic), 32'(l * Hd));
    check_eq("busy_cycles", 32'(busyc), 32'((2 * l + 2) * Hd));
    check_eq("no_err_in_xfer", 32'(errc), 32'd0);
    check_eq("end_state", {29'd0, bus.spi_cs, bus.spi_clk, bus.spi_mosi}, 32'b100);
    last_rx = exp_rx;
  endtask

  // GAP: chip select stays high and nothing starts, even with start held.
  task automatic wait_gap();
    int viol;
    viol = 0;
    repeat (Hd) begin
      @(negedge clk);
      if (!bus.spi_cs || bus.busy || bus.done || bus.err) viol++;
    end
    check_eq("gap_quiet", 32'(viol), 32'd0);
    check_eq("rx_hold", 32'(bus.rx_data), 32'(last_rx));
  endtask

  task automatic err_test(input logic [7:0] bad_len);
    bus.tx_data = 8'($urandom);
    bus.len     = bad_len;
    bus.start   = 1'b1;
    @(negedge clk);
    check_eq("err_pulse", 32'(bus.err), 32'd1);
    check_eq("err_idle", {30'd0, bus.busy, bus.spi_cs}, 32'b01);
    check_eq("err_rx_hold", 32'(bus.rx_data), 32'(last_rx));
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("err_one_cycle", {30'd0, bus.err, bus.spi_cs}, 32'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph[2], lowc[2], hic[2], gapc[2], hdv[2];
    int k, donec;
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.tx_data = 8'h00;  bus.len = 8'd0;
    bus1.start = 1'b0; bus1.tx_data = 8'h00; bus1.len = 8'd0;
    bus4.start = 1'b0; bus4.tx_data = 8'h00; bus4.len = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {25'd0, bus.spi_cs, bus.spi_clk, bus.spi_mosi, bus.busy, bus.done,
             bus.err, 1'b0}, 32'b1000000);
    check_eq("rst_rx", 32'(bus.rx_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    err_test(8'd0);
    err_test(8'd9);

    run_xfer(8'hA5, 8, 8'h3C, 1'b0, 1'b0);
    wait_gap();
    run_xfer(8'h05, 3, 8'hA0, 1'b0, 1'b1);
    wait_gap();
    run_xfer(8'h01, 1, 8'h80, 1'b0, 1'b0);
    wait_gap();

    // Back-to-back with start held through the gap.
    run_xfer(8'hC3, 8, 8'h5A, 1'b1, 1'b0);
    wait_gap();
    run_xfer(8'h3C, 8, 8'hA5, 1'b0, 1'b0);
    wait_gap();

    // Reset after the fourth rising spi_clk.
    bus.tx_data = 8'hF0; bus.len = 8'd8; bus.start = 1'b1; slv_word = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (rises < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("reach_4th_rise", 32'(rises >= 4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_outputs", {28'd0, bus.spi_cs, bus.spi_clk, bus.busy, bus.spi_mosi}, 32'b1000);
    check_eq("abort_rx", 32'(bus.rx_data), 32'd0);
    donec = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) donec++;
    end
    check_eq("abort_no_done", 32'(donec), 32'd0);
    rst_n = 1'b1;
    last_rx = 8'h00;
    @(negedge clk);
    run_xfer(8'h96, 8, 8'h69, 1'b0, 1'b0);
    wait_gap();

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        err_test(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255)));
      end
      run_xfer(8'($urandom), int'($urandom_range(1, 8)), 8'($urandom), 1'b0,
               1'($urandom_range(0, 1)));
      wait_gap();
    end

    // HALF_DIV=1 and HALF_DIV=4 timing, start held for two transfers.
    hdv = '{1, 4};
    ph = '{0, 0}; lowc = '{0, 0}; hic = '{0, 0}; gapc = '{0, 0};
    bus1.tx_data = 8'h5A; bus1.len = 8'd8; bus1.start = 1'b1;
    bus4.tx_data = 8'h5A; bus4.len = 8'd8; bus4.start = 1'b1;
    for (int n = 0; n < 400 && !(ph[0] == 2 && ph[1] == 2); n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        case (ph[i])
          0: begin
            if (!xcs[i]) lowc[i]++;
            if (xclk[i]) hic[i]++;
            if (xdone[i]) ph[i] = 1;
          end
          1: begin
            if (xcs[i]) gapc[i]++;
            else ph[i] = 2;
          end
          default: ;
        endcase
      end
    end
    bus1.start = 1'b0;
    bus4.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("hd_second_start", 32'(ph[i]), 32'd2);
      check_eq("hd_cs_low", 32'(lowc[i]), 32'(18 * hdv[i]));
      check_eq("hd_clk_high", 32'(hic[i]), 32'(8 * hdv[i]));
      check_eq("hd_gap", 32'(gapc[i]), 32'(hdv[i]));
    end
    repeat (100) @(negedge clk);
    check_eq("hd_idle_after", {30'd0, xcs}, 32'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: MAX_WIDTH, default 8, maximum transfer length in bits and width of data ports.
REQ-002 Parameter: HALF_DIV, default 2, spi_clk half-period in clk cycles; legal range 1..255.
REQ-003 Parameter: LEN_W, default 8, width of len port; must satisfy 2^LEN_W > MAX_WIDTH.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a transfer; sampled only in IDLE.
REQ-007 tx_data  input  MAX_WIDTH  transmit word, right-aligned; bit len-1 sent first.
REQ-008 len  input  LEN_W  transfer length in bits, 1..MAX_WIDTH.
REQ-009 busy  output  1  high from the cycle after start is accepted until the cycle done pulses.
REQ-010 done  output  1  one-cycle pulse at transfer end; rx_data valid from this cycle.
REQ-011 err  output  1  one-cycle pulse when start is rejected for an illegal len.
REQ-012 rx_data  output  MAX_WIDTH  received word, right-aligned, upper bits zero.
REQ-013 spi_clk  output  1  serial clock, idle low (mode 0).
REQ-014 spi_mosi  output  1  serial data out.
REQ-015 spi_miso  input  1  serial data in.
REQ-016 spi_cs  output  1  chip select, active low.

Function
REQ-017 States SHALL be IDLE, SETUP, HIGH, LOW, HOLD, GAP; every state except IDLE lasts exactly HALF_DIV clk cycles, counted by a phase counter.
REQ-018 IDLE: start=1 with 1<=len<=MAX_WIDTH latches tx_data, len; next cycle spi_cs=0, spi_mosi=tx_data[len-1], state SETUP, busy=1.
REQ-019 IDLE: start=1 with len=0 or len>MAX_WIDTH pulses err next cycle; state, busy, spi_cs, rx_data unchanged.
REQ-020 start while busy SHALL be ignored, no err, no effect on transfer in progress.
REQ-021 SETUP -> HIGH: spi_clk=1; rising edge is the slave sampling edge.
REQ-022 HIGH: on its last cycle, spi_miso is shifted into the receive register LSB; HIGH -> LOW with spi_clk=0.
REQ-023 LOW: bit counter increments on entry; if bits sent < len, spi_mosi shows next bit (MSB-first) on entry and LOW -> HIGH after HALF_DIV; if bits sent == len, LOW -> HOLD.
REQ-024 Every rising spi_clk SHALL be followed by a falling spi_clk before spi_cs rises; exactly len rising edges per transfer.
REQ-025 HOLD: spi_clk=0, spi_cs=0; on exit spi_cs=1, spi_mosi=0, rx_data updated, done=1, busy=0, state GAP.
REQ-026 GAP: spi_cs held high HALF_DIV cycles, start ignored (busy=0, not sampled); then IDLE.
REQ-027 Transfer duration, spi_cs low: (2*len+2)*HALF_DIV clk cycles; start-to-done: (2*len+2)*HALF_DIV+1 cycles.
REQ-028 rx_data holds its value between done pulses; not cleared by a new start.
REQ-029 len=MAX_WIDTH SHALL transmit all bits; len=1 SHALL produce one spi_clk pulse.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, spi_cs=1, spi_clk=0, spi_mosi=0, busy=0, done=0, err=0, rx_data=0, counters 0.
REQ-031 Reset mid-transfer SHALL abort immediately with no done pulse; first start after rst_n release begins a fresh transfer.

Verification
REQ-032 Paired with the team's SPI slave adapter (MAX_WIDTH=8) expecting inp A5, out 3C, len 8: start tx_data=A5,len=8 -> slave reports A5 in 8 bits, rx_data=3C at done, no $stop.
REQ-033 len=3, tx_data=05, slave out pattern A0 -> slave gets 5 in 3 bits, rx_data=05; exactly 3 spi_clk rising edges.
REQ-034 HALF_DIV=1 and HALF_DIV=4, len=8 -> spi_cs low exactly 18 and 72 clk cycles; spi_clk duty 50%; GAP >= HALF_DIV cycles before next spi_cs fall.
REQ-035 start with len=0, then len=9 -> err pulses each, spi_cs stays high, busy stays 0; start pulsed during transfer -> ignored.
REQ-036 rst_n asserted after 4th spi_clk rise -> spi_cs=1, spi_clk=0 same cycle, no done; next 8-bit transfer completes correctly.
REQ-037 Back-to-back starts (start held high) -> two complete transfers, separated by GAP, two done pulses, rx_data updated each.
